// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: instruction format codes, base opcodes,
// the canonical NOP word and the encoder FSM state type.
package rv_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: decoded fields in, 32-bit machine word out,
// with flags for an illegal format and a misaligned branch/jump offset.
module inst_pack
  import rv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err_fmt,
  output logic        err_align
);

  // B/J offsets are halfword multiples; imm[0] is never encoded.
  always_comb begin
    inst      = NOP_INST;
    err_fmt   = 1'b0;
    err_align = 1'b0;
    case (fmt)
      FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        inst      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err_align = imm[0];
      end
      FMT_U: inst = {imm[31:12], rd, opcode};
      FMT_J: begin
        inst      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err_align = imm[0];
      end
      default: err_fmt = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encode.sv
// Streaming RV32I encoder: packs field bundles into machine words and emits
// them with sequential word addresses through a single output register.
module inst_encode
  import rv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_fmt,
  output logic                  err_align,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAPACITY = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

  // Handshake: a side transfers on a rising edge where its valid and ready are
  // both high; valid never drops and the payload never changes until transfer.

  enc_state_e state, state_nxt;

  logic [31:0]         pk_inst;
  logic                pk_err_fmt;
  logic                pk_err_align;
  logic                accept;
  logic                xfer;
  logic [ADDR_WIDTH:0] count_inc;

  inst_pack u_pack (
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .inst      (pk_inst),
    .err_fmt   (pk_err_fmt),
    .err_align (pk_err_align)
  );

  assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign count_inc = count + (ADDR_WIDTH + 1)'(1);
  assign done      = (state == ST_FULL);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (xfer && count_inc == CAPACITY) state_nxt = ST_FULL;
        default: state_nxt = state;
      endcase
    end
  end

  // start outranks any same-cycle transfer; the held word is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inst      <= '0;
      addr      <= BASE;
      count     <= '0;
      err_fmt   <= 1'b0;
      err_align <= 1'b0;
    end else if (start) begin
      out_valid <= 1'b0;
      addr      <= BASE;
      count     <= '0;
      err_fmt   <= 1'b0;
      err_align <= 1'b0;
    end else begin
      if (xfer) begin
        addr  <= addr + ADDR_WIDTH'(1);
        count <= count_inc;
      end
      if (accept) begin
        inst      <= pk_inst;
        out_valid <= 1'b1;
        err_fmt   <= err_fmt | pk_err_fmt;
        err_align <= err_align | pk_err_align;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
